// File: rtl/tdm_demux_sched.sv
// -----------------------------------------------------------------------------
// tdm_demux_sched
//
// Sequencing controller for a 1-to-8 demultiplexer. Words arriving on a single
// valid/ready stream are handed out round-robin over the enabled subset of
// eight output channels. One word is in flight at a time: the controller
// takes a word (RUN), holds it for the scheduled channel until that channel
// accepts (HOLD), then moves on to the next enabled channel.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           pulse: begin scheduling with en_mask (ignored if 0)
//   stop            pulse: finish the word in flight, then go idle
//   en_mask[7:0]    channel enables, sampled at start and at frame boundaries
//   in_valid/ready  input word handshake, in_data[DW-1:0] is the word
//   out_data        word held for the selected channel
//   out_valid[7:0]  one-hot, bit sel set while a word is held
//   out_ready[7:0]  per-channel accept, only bit sel is observed
//   sel[2:0]        currently scheduled channel
//   busy            controller is scheduling (RUN or HOLD)
//   frame_done      one-cycle pulse when the last enabled channel accepts
//   frame_cnt       completed frames since start, wraps
// -----------------------------------------------------------------------------
module tdm_demux_sched #(
    parameter int DW  = 8,
    parameter int FCW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic [7:0]     en_mask,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic [DW-1:0]  out_data,
    output logic [7:0]     out_valid,
    input  logic [7:0]     out_ready,
    output logic [2:0]     sel,
    output logic           busy,
    output logic           frame_done,
    output logic [FCW-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_e;

    state_e         state_q;
    logic [7:0]     shadow_q;   // channel set used for the current frame
    logic [2:0]     sel_q;
    logic           pend_q;     // stop seen, honour at next word boundary
    logic [DW-1:0]  data_q;
    logic [7:0]     valid_q;
    logic           done_q;
    logic [FCW-1:0] cnt_q;

    // Index of the lowest set bit; 0 for an empty mask (never used that way).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Next enabled channel strictly above sel_q; no hit means the frame wraps.
    logic       nxt_found;
    logic [2:0] nxt_idx;
    logic [7:0] reload_mask;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (3'(i) > sel_q && shadow_q[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = 3'(i);
            end
        end
        // An all-zero mask at a frame boundary would strand the scheduler,
        // so the previous channel set is kept instead.
        reload_mask = (en_mask != 8'd0) ? en_mask : shadow_q;
    end

    wire stop_now = pend_q | stop;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data_q is a plain register, not a memory, so it is reset
            // along with the control state to give a defined out_data.
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            sel_q    <= '0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // start wins over a simultaneous stop; pend_q is already 0.
                    if (start && en_mask != 8'd0) begin
                        shadow_q <= en_mask;
                        sel_q    <= lowest_set(en_mask);
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        valid_q <= 8'd1 << sel_q;
                        pend_q  <= stop;
                        state_q <= ST_HOLD;
                    end else if (stop) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (out_ready[sel_q]) begin
                        valid_q <= '0;
                        if (nxt_found) begin
                            sel_q <= nxt_idx;
                        end else begin
                            done_q   <= 1'b1;
                            cnt_q    <= cnt_q + FCW'(1);
                            shadow_q <= reload_mask;
                            sel_q    <= lowest_set(reload_mask);
                        end
                        pend_q  <= 1'b0;
                        state_q <= stop_now ? ST_IDLE : ST_RUN;
                    end else if (stop) begin
                        pend_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign sel        = sel_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_tdm_demux_sched.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_sched
//
// Directed scenarios with literal expectations, followed by a randomized
// phase. A behavioural model (ordered list of enabled channels plus a position
// in it) predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux_sched;

    localparam int DW  = 8;
    localparam int FCW = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           stop;
    logic [7:0]     en_mask;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic [DW-1:0]  out_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [2:0]     sel;
    logic           busy;
    logic           frame_done;
    logic [FCW-1:0] frame_cnt;

    tdm_demux_sched #(.DW(DW), .FCW(FCW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .en_mask    (en_mask),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 waiting for an input word, 2 holding a word
    int             m_mode   = 0;
    logic [7:0]     m_shadow = '0;
    int             m_list[$];
    int             m_pos    = 0;
    logic [DW-1:0]  m_data   = '0;
    logic [7:0]     m_valid  = '0;
    logic [2:0]     m_sel    = '0;
    logic           m_done   = 1'b0;
    logic [FCW-1:0] m_cnt    = '0;
    logic           m_pend   = 1'b0;

    function automatic void m_build();
        m_list.delete();
        for (int i = 0; i < 8; i++) if (m_shadow[i]) m_list.push_back(i);
        m_pos = 0;
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_shadow = '0; m_list.delete(); m_pos = 0;
        m_data = '0; m_valid = '0; m_sel = '0; m_done = 1'b0;
        m_cnt = '0; m_pend = 1'b0;
    endfunction

    function automatic void m_step();
        m_done = 1'b0;
        case (m_mode)
            0: if (start && en_mask != 0) begin
                m_shadow = en_mask;
                m_build();
                m_sel  = 3'(m_list[0]);
                m_cnt  = '0;
                m_mode = 1;
            end
            1: if (in_valid) begin
                m_data  = in_data;
                m_valid = 8'(1 << m_sel);
                m_pend  = stop;
                m_mode  = 2;
            end else if (stop) begin
                m_mode = 0;
            end
            default: begin
                if (stop) m_pend = 1'b1;
                if (out_ready[m_sel]) begin
                    m_valid = '0;
                    m_pos++;
                    if (m_pos == m_list.size()) begin
                        m_done = 1'b1;
                        m_cnt++;
                        if (en_mask != 0) m_shadow = en_mask;
                        m_build();
                    end
                    m_sel = 3'(m_list[m_pos]);
                    if (m_pend) begin
                        m_pend = 1'b0;
                        m_mode = 0;
                    end else begin
                        m_mode = 1;
                    end
                end
            end
        endcase
    endfunction

    // Single compare process: advance model on each edge, compare 1 ns later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_step();
            #1;
            check("mdl_in_ready",   32'(in_ready),   32'(m_mode == 1));
            check("mdl_busy",       32'(busy),       32'(m_mode != 0));
            check("mdl_out_valid",  32'(out_valid),  32'(m_valid));
            check("mdl_out_data",   32'(out_data),   32'(m_data));
            check("mdl_sel",        32'(sel),        32'(m_sel));
            check("mdl_frame_done", 32'(frame_done), 32'(m_done));
            check("mdl_frame_cnt",  32'(frame_cnt),  32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers (drive on negedge) ----------------
    task automatic pulse_start(input logic [7:0] m);
        en_mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Waits (bounded) for in_ready, presents one word for one cycle, and
    // returns at the negedge after the transfer edge.
    task automatic push_word(input logic [DW-1:0] d);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; en_mask = '0;
        in_valid = 1'b0; in_data = '0; out_ready = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   32'h0);
        check("rst_out_data",   32'(out_data),   32'h0);
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_sel",        32'(sel),        32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_frame_cnt",  32'(frame_cnt),  32'h0);
        rst_n = 1'b1;
        pulse_start(8'h00);
        check("start_mask0_busy", 32'(busy), 32'h0);
        pulse_stop();
        check("stop_idle_busy", 32'(busy), 32'h0);

        // Full rotation
        out_ready = 8'hFF;
        pulse_start(8'hFF);
        check("rot_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            push_word(8'(8'h10 + k));
            check("rot_valid", 32'(out_valid), 32'(1 << k));
            check("rot_sel",   32'(sel),       32'(k));
            check("rot_data",  32'(out_data),  32'(8'h10 + k));
            check("rot_frame_done_low", 32'(frame_done), 32'h0);
        end
        @(negedge clk);
        check("rot_frame_done", 32'(frame_done), 32'h1);
        check("rot_frame_cnt",  32'(frame_cnt),  32'h1);
        check("rot_model_cnt",  32'(m_cnt),      32'h1);
        check("rot_sel_wrap",   32'(sel),        32'h0);
        @(negedge clk);
        check("rot_frame_done_pulse", 32'(frame_done), 32'h0);
        pulse_stop();
        check("rot_stop_busy", 32'(busy), 32'h0);

        // Sparse mask with back-pressure on channel 5
        out_ready = 8'hDF;
        pulse_start(8'b1010_0100);
        check("sparse_first_sel", 32'(sel), 32'h2);
        push_word(8'hA1);
        check("sparse_a_valid", 32'(out_valid), 32'h04);
        push_word(8'hB2);
        for (int i = 0; i < 4; i++) begin
            check("stall_sel",      32'(sel),       32'h5);
            check("stall_data",     32'(out_data),  32'hB2);
            check("stall_valid",    32'(out_valid), 32'h20);
            check("stall_in_ready", 32'(in_ready),  32'h0);
            @(negedge clk);
        end
        out_ready = 8'hFF;
        push_word(8'hC3);
        check("sparse_c_sel",   32'(sel),       32'h7);
        check("sparse_c_valid", 32'(out_valid), 32'h80);
        @(negedge clk);
        check("sparse_frame_done", 32'(frame_done), 32'h1);
        check("sparse_frame_cnt",  32'(frame_cnt),  32'h1);
        check("sparse_sel_wrap",   32'(sel),        32'h2);
        pulse_stop();

        // Mask change mid-frame only takes effect at the boundary
        pulse_start(8'h03);
        push_word(8'h31);
        en_mask = 8'h80;
        push_word(8'h32);
        check("mchg_second_sel",   32'(sel),       32'h1);
        check("mchg_second_valid", 32'(out_valid), 32'h02);
        check("mchg_cnt_before",   32'(frame_cnt), 32'h0);
        @(negedge clk);
        check("mchg_cnt_after",  32'(frame_cnt), 32'h1);
        check("mchg_sel_reload", 32'(sel),       32'h7);
        push_word(8'h33);
        check("mchg_third_valid", 32'(out_valid), 32'h80);
        check("mchg_third_data",  32'(out_data),  32'h33);
        @(negedge clk);
        check("mchg_cnt_single", 32'(frame_cnt), 32'h2);
        pulse_stop();

        // Stop while holding a word for channel 3
        out_ready = 8'h00;
        pulse_start(8'h08);
        push_word(8'h44);
        check("hstop_valid", 32'(out_valid), 32'h08);
        pulse_stop();
        check("hstop_busy_held",  32'(busy),      32'h1);
        check("hstop_valid_held", 32'(out_valid), 32'h08);
        out_ready = 8'h08;
        @(negedge clk);
        check("hstop_busy",     32'(busy),      32'h0);
        check("hstop_in_ready", 32'(in_ready),  32'h0);
        check("hstop_valid0",   32'(out_valid), 32'h0);
        check("hstop_sel",      32'(sel),       32'h3);
        repeat (3) @(negedge clk);
        check("hstop_sel_stays",  32'(sel),  32'h3);
        check("hstop_busy_stays", 32'(busy), 32'h0);

        // Async reset while holding a word
        pulse_start(8'h08);
        push_word(8'h55);
        @(negedge clk);
        check("areset_cnt_pre", 32'(frame_cnt), 32'h1);
        out_ready = 8'h00;
        push_word(8'h66);
        check("areset_valid_pre", 32'(out_valid), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'h0);
        check("areset_cnt",   32'(frame_cnt), 32'h0);
        check("areset_busy",  32'(busy),      32'h0);
        check("areset_data",  32'(out_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0)
                en_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 8'hFF;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
